// File: rtl/adderc_pipe_if.sv
// adderc_pipe_if: operand/result bus of the pipelined add/sub unit.
interface adderc_pipe_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic             in_valid;
    logic             sub_nadd;
    logic             cin;
    logic             sat;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    modport master (
        output enable, in_valid, sub_nadd, cin, sat, a, b,
        input  out_valid, out, cout, ovf
    );
    modport slave (
        input  enable, in_valid, sub_nadd, cin, sat, a, b,
        output out_valid, out, cout, ovf
    );
endinterface

// File: rtl/adderc_pipe.sv
// adderc_pipe: carry-split pipelined add/sub, one chunk of the carry chain resolved per stage.
module adderc_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic         clk,
    input logic         srst_n,
    adderc_pipe_if.slave bus
);
    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
    localparam int L     = STAGES - 1;
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [WIDTH:0]   wide_t;
    word_t a_p[STAGES], a_d[STAGES], a_q[STAGES];
    word_t b_p[STAGES], b_d[STAGES], b_q[STAGES];
    word_t r_p[STAGES], r_d[STAGES], r_q[STAGES];
    logic  c_p[STAGES], c_d[STAGES], c_q[STAGES];
    logic  v_p[STAGES], v_d[STAGES], v_q[STAGES];
    logic  s_p[STAGES], s_d[STAGES], s_q[STAGES];
    logic  ovf_d, ovf_q;
    always_comb begin
        word_t m, r;
        wide_t sum;
        logic  f;
        int    lo, hi;
        // bubbles enter as all-zero slots so idle outputs read as zeros
        a_p[0] = bus.in_valid ? bus.a : '0;
        b_p[0] = bus.in_valid ? (bus.sub_nadd ? ~bus.b : bus.b) : '0;
        r_p[0] = '0;
        c_p[0] = bus.in_valid & bus.cin;
        v_p[0] = bus.in_valid;
        s_p[0] = bus.in_valid & bus.sat;
        for (int k = 1; k < STAGES; k++) begin
            a_p[k] = a_q[k-1];
            b_p[k] = b_q[k-1];
            r_p[k] = r_q[k-1];
            c_p[k] = c_q[k-1];
            v_p[k] = v_q[k-1];
            s_p[k] = s_q[k-1];
        end
        m   = '0;
        r   = '0;
        sum = '0;
        f   = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            lo = k * CHUNK;
            hi = (k == L) ? WIDTH - 1 : lo + CHUNK - 1;
            m   = word_t'((wide_t'(1) << (hi + 1)) - (wide_t'(1) << lo));
            sum = {1'b0, a_p[k] & m} + {1'b0, b_p[k] & m} + (wide_t'(c_p[k]) << lo);
            r   = (r_p[k] & ~m) | (sum[WIDTH-1:0] & m);
            f   = (a_p[k][WIDTH-1] == b_p[k][WIDTH-1]) && (r[WIDTH-1] != a_p[k][WIDTH-1]);
            a_d[k] = bus.enable ? a_p[k] : a_q[k];
            b_d[k] = bus.enable ? b_p[k] : b_q[k];
            v_d[k] = bus.enable ? v_p[k] : v_q[k];
            s_d[k] = bus.enable ? s_p[k] : s_q[k];
            c_d[k] = bus.enable ? |(sum & (wide_t'(1) << (hi + 1))) : c_q[k];
            r_d[k] = !bus.enable ? r_q[k] :
                     (k == L && s_p[k] && f) ? {a_p[k][WIDTH-1], {(WIDTH-1){~a_p[k][WIDTH-1]}}} : r;
        end
        ovf_d = bus.enable ? f : ovf_q;
    end
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= srst_n ? a_d[k] : '0;
            b_q[k] <= srst_n ? b_d[k] : '0;
            r_q[k] <= srst_n ? r_d[k] : '0;
            c_q[k] <= srst_n ? c_d[k] : 1'b0;
            v_q[k] <= srst_n ? v_d[k] : 1'b0;
            s_q[k] <= srst_n ? s_d[k] : 1'b0;
        end
        ovf_q <= srst_n ? ovf_d : 1'b0;
    end
    assign bus.out_valid = v_q[L];
    assign bus.out       = r_q[L];
    assign bus.cout      = c_q[L];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adderc_pipe.sv
// tb_adderc_pipe: three configurations driven in lockstep against a delay-line arithmetic model.
module tb_adderc_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic srst_n, en, iv, sub, cin, sat;
    logic [16:0] a, b;
    int n_chk = 0, n_fail = 0, cnt;
    bit chk_on = 1'b0;
    adderc_pipe_if #(.WIDTH(16)) i16 ();
    adderc_pipe_if #(.WIDTH(16)) i1 ();
    adderc_pipe_if #(.WIDTH(17)) i17 ();
    assign i16.enable = en;  assign i1.enable = en;  assign i17.enable = en;
    assign i16.in_valid = iv; assign i1.in_valid = iv; assign i17.in_valid = iv;
    assign i16.sub_nadd = sub; assign i1.sub_nadd = sub; assign i17.sub_nadd = sub;
    assign i16.cin = cin; assign i1.cin = cin; assign i17.cin = cin;
    assign i16.sat = sat; assign i1.sat = sat; assign i17.sat = sat;
    assign i16.a = a[15:0]; assign i1.a = a[15:0]; assign i17.a = a;
    assign i16.b = b[15:0]; assign i1.b = b[15:0]; assign i17.b = b;
    adderc_pipe #(.WIDTH(16), .STAGES(4)) d16 (.clk(clk), .srst_n(srst_n), .bus(i16));
    adderc_pipe #(.WIDTH(16), .STAGES(1)) d1  (.clk(clk), .srst_n(srst_n), .bus(i1));
    adderc_pipe #(.WIDTH(17), .STAGES(4)) d17 (.clk(clk), .srst_n(srst_n), .bus(i17));
    typedef struct packed {logic v; logic [16:0] o; logic c; logic f;} res_t;
    res_t p16[4], p1[1], p17[4];
    function automatic res_t calc(int w, logic [16:0] x, logic [16:0] y, logic s, logic c, logic t);
        longint unsigned mk, xx, yy, sm;
        logic xm, ym, rm;
        res_t r;
        mk = (64'd1 << w) - 1;
        xx = longint'(x) & mk;
        yy = longint'(y);
        if (s) yy = ~yy;
        yy = yy & mk;
        sm = xx + yy + longint'(c);
        r.v = 1'b1;
        r.c = sm[w];
        r.o = 17'(sm & mk);
        xm = xx[w-1]; ym = yy[w-1]; rm = r.o[w-1];
        r.f = (xm == ym) && (rm != xm);
        if (t && r.f) r.o = xm ? 17'(64'd1 << (w - 1)) : 17'(mk >> 1);
        return r;
    endfunction
    always @(posedge clk) begin
        if (!srst_n) begin
            p16 = '{default: '0}; p17 = '{default: '0}; p1 = '{default: '0};
        end else if (en) begin
            for (int i = 3; i > 0; i--) begin
                p16[i] = p16[i-1];
                p17[i] = p17[i-1];
            end
            p16[0] = iv ? calc(16, a, b, sub, cin, sat) : '0;
            p1[0]  = iv ? calc(16, a, b, sub, cin, sat) : '0;
            p17[0] = iv ? calc(17, a, b, sub, cin, sat) : '0;
        end
    end
    task automatic check(string nm, logic [16:0] act, logic [16:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic cmp(string nm, res_t e, logic v, logic [16:0] o, logic c, logic f);
        check({nm, ".valid"}, 17'(v), 17'(e.v));
        check({nm, ".out"}, o, e.o);
        check({nm, ".cout"}, 17'(c), 17'(e.c));
        check({nm, ".ovf"}, 17'(f), 17'(e.f));
    endtask
    always @(negedge clk) begin
        if (chk_on) begin
            cmp("w16s4", p16[3], i16.out_valid, {1'b0, i16.out}, i16.cout, i16.ovf);
            cmp("w16s1", p1[0], i1.out_valid, {1'b0, i1.out}, i1.cout, i1.ovf);
            cmp("w17s4", p17[3], i17.out_valid, i17.out, i17.cout, i17.ovf);
        end
    end
    task automatic drive(logic [16:0] x, logic [16:0] y, logic s, logic c, logic t);
        a = x; b = y; sub = s; cin = c; sat = t; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
    endtask
    res_t e;
    logic [16:0] cn[6] = '{17'h00000, 17'h1FFFF, 17'h0FFFF, 17'h10000, 17'h07FFF, 17'h08000};
    initial begin
        srst_n = 1'b0; en = 1'b1; iv = 1'b0; sub = 1'b0; cin = 1'b0; sat = 1'b0; a = '0; b = '0;
        e = calc(16, 17'h1, 17'h2, 1'b0, 1'b1, 1'b0);         check("model.add", e.o, 17'h4);
        e = calc(16, 17'hFFFF, 17'hFFFF, 1'b0, 1'b0, 1'b0);   check("model.neg", {e.o[15:0], e.c}, {16'hFFFE, 1'b1});
        e = calc(16, 17'h1, 17'h2, 1'b1, 1'b1, 1'b0);         check("model.sub", {e.o[15:0], e.c}, {16'hFFFF, 1'b0});
        e = calc(16, 17'h7FFF, 17'h1, 1'b0, 1'b0, 1'b0);      check("model.wrap", {e.o[15:0], e.f}, {16'h8000, 1'b1});
        e = calc(16, 17'h7FFF, 17'h1, 1'b0, 1'b0, 1'b1);      check("model.satp", {e.o[15:0], e.f}, {16'h7FFF, 1'b1});
        e = calc(16, 17'h8000, 17'h1, 1'b1, 1'b1, 1'b1);      check("model.satn", {e.o[15:0], e.f, e.c}, {16'h8000, 2'b11});
        e = calc(17, 17'h0FFFF, 17'h1, 1'b0, 1'b0, 1'b1);     check("model.sat17", {e.o, e.f}, {17'h0FFFF, 1'b1});
        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.valid", 17'(i16.out_valid), 17'h0);
        check("rst.out", 17'(i16.out), 17'h0);
        srst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive(17'h1, 17'h2, 1'b0, 1'b1, 1'b0);
        check("lat.s1.valid", 17'(i1.out_valid), 17'h1);
        check("lat.s1.out", 17'(i1.out), 17'h4);
        check("lat.e0", 17'(i16.out_valid), 17'h0);
        @(negedge clk); check("lat.e1", 17'(i16.out_valid), 17'h0);
        @(negedge clk); check("lat.e2", 17'(i16.out_valid), 17'h0);
        @(negedge clk);
        check("lat.e3.valid", 17'(i16.out_valid), 17'h1);
        check("lat.e3.out", {i16.out, i16.cout}, {16'h4, 1'b0});
        check("lat.w17.out", i17.out, 17'h4);
        repeat (2) @(negedge clk);
        drive(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b0, 1'b0);
        drive(17'h1, 17'h2, 1'b1, 1'b1, 1'b0);
        drive(17'h0FFF, 17'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); check("strm.0", {i16.out, i16.cout}, {16'hFFFE, 1'b1});
        @(negedge clk); check("strm.1", {i16.out, i16.cout}, {16'hFFFF, 1'b0});
        @(negedge clk); check("strm.2", 17'(i16.out), 17'h1000);
        repeat (2) @(negedge clk);
        drive(17'h7FFF, 17'h1, 1'b0, 1'b0, 1'b0);
        check("ovf.wrap", {i1.out, i1.ovf}, {16'h8000, 1'b1});
        drive(17'h7FFF, 17'h1, 1'b0, 1'b0, 1'b1);
        check("ovf.satp", {i1.out, i1.ovf}, {16'h7FFF, 1'b1});
        drive(17'h8000, 17'h1, 1'b1, 1'b1, 1'b1);
        check("ovf.satn", {i1.out, i1.ovf, i1.cout}, {16'h8000, 2'b11});
        drive(17'h0FFFF, 17'h1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("ovf.w17", {i17.out, i17.ovf}, {17'h0FFFF, 1'b1});
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) drive(17'($urandom), 17'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        cnt = 0; en = 1'b0; iv = 1'b1; a = 17'($urandom);
        repeat (3) begin @(negedge clk); cnt += int'(i16.out_valid); end
        en = 1'b1; iv = 1'b0;
        repeat (6) begin @(negedge clk); cnt += int'(i16.out_valid); end
        check("stall.count", 17'(cnt), 17'h3);
        for (int i = 0; i < 3; i++) drive(17'($urandom), 17'($urandom), 1'b0, 1'b0, 1'b0);
        cnt = 0; srst_n = 1'b0; iv = 1'b1;
        @(negedge clk); cnt += int'(i16.out_valid);
        srst_n = 1'b1; iv = 1'b0;
        repeat (5) begin @(negedge clk); cnt += int'(i16.out_valid); end
        check("rstmid.count", 17'(cnt), 17'h0);
        repeat (3000) begin
            en = $urandom_range(0, 3) != 0;
            srst_n = $urandom_range(0, 63) != 0;
            iv = $urandom_range(0, 3) != 0;
            sub = 1'($urandom); cin = 1'($urandom); sat = 1'($urandom);
            a = $urandom_range(0, 1) != 0 ? 17'($urandom) : cn[$urandom_range(0, 5)];
            b = $urandom_range(0, 1) != 0 ? 17'($urandom) : cn[$urandom_range(0, 5)];
            @(negedge clk);
        end
        srst_n = 1'b1; en = 1'b1; iv = 1'b0;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
